// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA capture path and its frame-buffer
// partner (address/color widths must match vga_memory).
package vga_pkg;
   localparam int DEF_H_TOTAL  = 800;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_OFFSET = 144;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_TOTAL  = 521;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_OFFSET = 31;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_SHIFT    = 2;

   localparam int ADDR_W  = 15;
   localparam int COLOR_W = 12;
   localparam int HCNT_W  = 11;
   localparam int VCNT_W  = 10;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEEK    = 2'd1;
   localparam logic [1:0] ST_VERIFY  = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/vga_capture_if.sv
// Ready/valid write port from the capture block into a frame buffer.
interface vga_capture_if;
   import vga_pkg::*;
   logic               o_wrValid;
   logic               i_wrReady;
   logic [ADDR_W-1:0]  o_wrAddr;
   logic [COLOR_W-1:0] o_wrData;

   modport master (output o_wrValid, o_wrAddr, o_wrData, input i_wrReady);
   modport slave  (input o_wrValid, o_wrAddr, o_wrData, output i_wrReady);
endinterface

// File: rtl/vga_syncTrack.sv
// Sync edge detector plus position counter; o_cnt is aligned with the
// input sample of the current cycle, o_lenOk checks the previous length.
module vga_syncTrack #(
   parameter int TOTAL      = 800,
   parameter int CNT_W      = 11,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_sync,
   input  logic             i_step,
   output logic             o_edge,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_lenOk
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);

   logic             sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d  = i_sync;
      o_edge  = (i_sync ^ ACTIVE_LOW) & ~(sync_q ^ ACTIVE_LOW);
      cnt_d   = cnt_q;
      if (o_edge)
         cnt_d = '0;
      else if (i_step && cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
      o_cnt   = cnt_d;
      o_lenOk = (cnt_q == LAST);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_q <= ACTIVE_LOW;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/vga_capture.sv
// VGA sink: recovers timing, verifies geometry, and writes a 1-in-2^SHIFT
// downscaled frame into a frame buffer over a ready/valid port.
module vga_capture import vga_pkg::*; #(
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_OFFSET = DEF_H_OFFSET,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_OFFSET = DEF_V_OFFSET,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int SHIFT    = DEF_SHIFT,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_enable,
   input  logic [COLOR_W-1:0] i_color,
   input  logic               i_hSync,
   input  logic               i_vSync,
   vga_capture_if.master      wr,
   output logic               o_locked,
   output logic               o_frameDone,
   output logic               o_overflow,
   output logic               o_timingErr
);
   localparam logic [HCNT_W-1:0] H_LO = HCNT_W'(H_OFFSET);
   localparam logic [HCNT_W-1:0] H_HI = HCNT_W'(H_OFFSET + H_ACTIVE);
   localparam logic [VCNT_W-1:0] V_LO = VCNT_W'(V_OFFSET);
   localparam logic [VCNT_W-1:0] V_HI = VCNT_W'(V_OFFSET + V_ACTIVE);
   localparam logic [ADDR_W-1:0] OUT_W  = ADDR_W'(H_ACTIVE >> SHIFT);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'((V_ACTIVE >> SHIFT) * (H_ACTIVE >> SHIFT) - 1);

   logic              h_edge, v_edge, h_ok, v_ok;
   logic [HCNT_W-1:0] hcnt, hrel;
   logic [VCNT_W-1:0] vcnt, vrel;
   logic              sample, h_bad, v_bad, accept;

   logic [1:0] state_q, state_d;
   logic       h_arm_q, h_arm_d;
   logic       valid_q, valid_d;
   logic       done_q, done_d;
   logic       ovf_q, ovf_d;
   logic       terr_q, terr_d;
   wr_req_t    req_q, req_d;

   vga_syncTrack #(.TOTAL(H_TOTAL), .CNT_W(HCNT_W), .ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_h (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sync(i_hSync), .i_step(1'b1),
      .o_edge(h_edge), .o_cnt(hcnt), .o_lenOk(h_ok));

   vga_syncTrack #(.TOTAL(V_TOTAL), .CNT_W(VCNT_W), .ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_v (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sync(i_vSync), .i_step(h_edge),
      .o_edge(v_edge), .o_cnt(vcnt), .o_lenOk(v_ok));

   always_comb begin
      hrel   = hcnt - H_LO;
      vrel   = vcnt - V_LO;
      sample = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI) &&
               (hrel[SHIFT-1:0] == '0) && (vrel[SHIFT-1:0] == '0);
      // The first line edge after arming is skipped: hcnt was free-running before.
      h_bad  = h_edge & h_arm_q & ~h_ok;
      v_bad  = v_edge & ~v_ok;
      accept = valid_q & wr.i_wrReady;

      state_d = state_q;
      h_arm_d = h_arm_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      terr_d  = terr_q;
      req_d   = req_q;

      if (accept) begin
         valid_d = 1'b0;
         done_d  = (req_q.addr == LAST_A);
      end

      if (!i_enable) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
         ovf_d   = 1'b0;
         terr_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SEEK;
            ST_SEEK: begin
               if (v_edge) begin
                  state_d = ST_VERIFY;
                  h_arm_d = 1'b0;
               end
            end
            default: begin
               if (h_edge) h_arm_d = 1'b1;
               if (h_bad || v_bad) begin
                  terr_d  = 1'b1;
                  state_d = ST_SEEK;
               end else if (state_q == ST_VERIFY) begin
                  if (v_edge) state_d = ST_CAPTURE;
               end else if (sample) begin
                  if (valid_q && !wr.i_wrReady) begin
                     ovf_d = 1'b1;
                  end else begin
                     valid_d    = 1'b1;
                     req_d.addr = ADDR_W'(vrel >> SHIFT) * OUT_W + ADDR_W'(hrel >> SHIFT);
                     req_d.data = i_color;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         h_arm_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         terr_q  <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         h_arm_q <= h_arm_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         terr_q  <= terr_d;
         req_q   <= req_d;
      end
   end

   assign wr.o_wrValid = valid_q;
   assign wr.o_wrAddr  = req_q.addr;
   assign wr.o_wrData  = req_q.data;
   assign o_locked     = (state_q == ST_CAPTURE);
   assign o_frameDone  = done_q;
   assign o_overflow   = ovf_q;
   assign o_timingErr  = terr_q;
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 40x30 geometry; an active-low
// and an active-high instance run side by side on the same pixel stream.
module tb_vga_capture;
   import vga_pkg::*;

   localparam int HT = 40, HS = 4, HO = 8, HA = 16;
   localparam int VT = 30, VS = 2, VO = 4, VA = 16;
   localparam int SH = 2;
   localparam int W  = HA >> SH;
   localparam int NW = W * (VA >> SH);

   logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, rdy = 1'b1;
   logic hs = 1'b1, vs = 1'b1;
   logic [11:0] color = '0;
   logic lk_lo, fd_lo, ov_lo, te_lo, lk_hi, fd_hi, ov_hi, te_hi;

   always #5 clk = ~clk;

   vga_capture_if wr_lo ();
   vga_capture_if wr_hi ();
   assign wr_lo.i_wrReady = rdy;
   assign wr_hi.i_wrReady = rdy;

   vga_capture #(.H_TOTAL(HT), .H_OFFSET(HO), .H_ACTIVE(HA), .V_TOTAL(VT), .V_OFFSET(VO),
                 .V_ACTIVE(VA), .SHIFT(SH), .SYNC_ACTIVE_LOW(1'b1)) dut_lo (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_color(color),
      .i_hSync(hs), .i_vSync(vs), .wr(wr_lo),
      .o_locked(lk_lo), .o_frameDone(fd_lo), .o_overflow(ov_lo), .o_timingErr(te_lo));

   vga_capture #(.H_TOTAL(HT), .H_OFFSET(HO), .H_ACTIVE(HA), .V_TOTAL(VT), .V_OFFSET(VO),
                 .V_ACTIVE(VA), .SHIFT(SH), .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_color(color),
      .i_hSync(~hs), .i_vSync(~vs), .wr(wr_hi),
      .o_locked(lk_hi), .o_frameDone(fd_hi), .o_overflow(ov_hi), .o_timingErr(te_hi));

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] pix(input int p, input int l);
      if (p == HO + 4 && l == VO + 4) return 12'hABC;
      return {6'(l), 6'(p)};
   endfunction

   function automatic logic [11:0] exp_pix(input int a);
      return pix(HO + ((a % W) << SH), VO + ((a / W) << SH));
   endfunction

   // Pixel generator: sync pulses start at p=0 / l=0, one line may be cut short.
   int gp = 0, gl = 0, fcnt = 0, cyc = 0, cyc_drv = -1;
   bit gen_on = 0, short_req = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk); #1;
      if (gen_on) begin
         hs    = (gp < HS) ? 1'b0 : 1'b1;
         vs    = (gl < VS) ? 1'b0 : 1'b1;
         color = pix(gp, gl);
         if (gp == 0 && gl == 0) fcnt++;
         if (gp == HO + 4 && gl == VO + 4 && fcnt == 2) cyc_drv = cyc;
         gp++;
         if (gp == ((short_req && gl == 10) ? HT - 1 : HT)) begin
            if (short_req && gl == 10) short_req = 0;
            gp = 0;
            gl = (gl == VT - 1) ? 0 : gl + 1;
         end
      end
   end

   // Write monitor and ready stall control, evaluated away from the clock edge.
   logic [14:0] qa0[$], qa1[$];
   logic [11:0] qd0[$], qd1[$];
   int fd0 = 0, fd1 = 0, trig_addr = -1, trig_len = 0, stall = 0, unstable = 0, cyc_vld = -1;
   logic [14:0] held_a = '0;
   logic [11:0] held_d = '0;
   bit v_prev = 0;

   initial forever begin
      @(negedge clk);
      if (stall > 0) begin
         if (wr_lo.o_wrAddr !== held_a || wr_lo.o_wrData !== held_d) unstable++;
         stall--;
         if (stall == 0) rdy = 1'b1;
      end else if (trig_addr >= 0 && wr_lo.o_wrValid && int'(wr_lo.o_wrAddr) == trig_addr) begin
         rdy       = 1'b0;
         stall     = trig_len;
         trig_addr = -1;
         held_a    = wr_lo.o_wrAddr;
         held_d    = wr_lo.o_wrData;
      end
      if (wr_lo.o_wrValid && !v_prev && wr_lo.o_wrAddr == 15'd5 && cyc_vld < 0) cyc_vld = cyc;
      v_prev = wr_lo.o_wrValid;
      if (wr_lo.o_wrValid && rdy) begin qa0.push_back(wr_lo.o_wrAddr); qd0.push_back(wr_lo.o_wrData); end
      if (wr_hi.o_wrValid && rdy) begin qa1.push_back(wr_hi.o_wrAddr); qd1.push_back(wr_hi.o_wrData); end
      if (fd_lo) fd0++;
      if (fd_hi) fd1++;
   end

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic wait_frame(input int f, input string tag);
      int n;
      n = 0;
      while (fcnt < f && n < 3 * HT * VT) begin @(posedge clk); n++; end
      chk(tag, 32'(fcnt >= f), 1);
      #2;
   endtask

   task automatic wait_line(input int l, input string tag);
      int n;
      n = 0;
      while (gl != l && n < 2 * HT * VT) begin @(posedge clk); n++; end
      chk(tag, gl, l);
      #2;
   endtask

   task automatic clear_log();
      qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
      fd0 = 0; fd1 = 0;
   endtask

   // Expected stream: addresses 0..NW-1 repeating, with one address optionally dropped.
   task automatic check_seq(input string tag, input int n, input int skip);
      int bad0, bad1, a;
      bad0 = 0; bad1 = 0;
      chk({tag, "_n_lo"}, qa0.size(), n);
      chk({tag, "_n_hi"}, qa1.size(), n);
      a = 0;
      foreach (qa0[i]) begin
         if (a == skip) a++;
         if (qa0[i] !== 15'(a % NW) || qd0[i] !== exp_pix(a % NW)) bad0++;
         a++;
      end
      a = 0;
      foreach (qa1[i]) begin
         if (a == skip) a++;
         if (qa1[i] !== 15'(a % NW) || qd1[i] !== exp_pix(a % NW)) bad1++;
         a++;
      end
      chk({tag, "_seq_lo"}, bad0, 0);
      chk({tag, "_seq_hi"}, bad1, 0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #11;
      chk("rst_valid", wr_lo.o_wrValid, 0);
      chk("rst_addr", wr_lo.o_wrAddr, 0);
      chk("rst_data", wr_lo.o_wrData, 0);
      chk("rst_locked", lk_lo, 0);
      chk("rst_done", fd_lo, 0);
      chk("rst_ovf", ov_lo, 0);
      chk("rst_terr", te_lo, 0);
      chk("rst_valid_hi", wr_hi.o_wrValid, 0);
      rst_n = 1'b1;
      en    = 1'b1;
      cycles(4);
      gen_on = 1;

      // Frame 1 verifies, frames 2 and 3 are captured.
      wait_frame(1, "f1_start");
      cycles(5 * HT);
      chk("f1_unlocked", lk_lo, 0);
      chk("f1_no_writes", qa0.size(), 0);
      wait_frame(2, "f2_start");
      cycles(2);
      chk("f2_locked_lo", lk_lo, 1);
      chk("f2_locked_hi", lk_hi, 1);
      wait_frame(4, "f4_start");
      cycles(2);
      check_seq("f23", 2 * NW, -1);
      chk("f23_done_lo", fd0, 2);
      chk("f23_done_hi", fd1, 2);
      chk("abc_data", qd0[5], 12'hABC);
      chk("abc_latency", cyc_vld, cyc_drv + 1);
      chk("f23_ovf", ov_lo, 0);
      chk("f23_terr", te_lo, 0);

      // Frame 4: a 3-cycle stall is absorbed, a 5-cycle stall drops addr 9.
      clear_log();
      trig_len = 3; trig_addr = 1;
      begin : w3
         int n;
         n = 0;
         while (qa0.size() < 3 && n < 20 * HT) begin @(posedge clk); n++; end
         chk("stall3_wait", 32'(qa0.size() >= 3), 1);
      end
      #2;
      chk("stall3_ovf", ov_lo, 0);
      trig_len = 5; trig_addr = 8;
      wait_line(25, "f4_l25");
      chk("stall5_ovf_lo", ov_lo, 1);
      chk("stall5_ovf_hi", ov_hi, 1);
      chk("stall_hold", unstable, 0);
      check_seq("f4", NW - 1, 9);
      chk("f4_done", fd0, 1);
      en = 1'b0;
      cycles(1);
      en = 1'b1;
      chk("en_clr_ovf", ov_lo, 0);
      chk("en_unlock", lk_lo, 0);

      // Frame 5 verifies, frame 6 captures until a short line breaks lock.
      clear_log();
      wait_frame(6, "f6_start");
      cycles(2);
      chk("f6_locked", lk_lo, 1);
      short_req = 1;
      wait_line(11, "f6_l11");
      cycles(5);
      chk("short_terr_lo", te_lo, 1);
      chk("short_terr_hi", te_hi, 1);
      chk("short_unlock", lk_lo, 0);
      check_seq("f6_part", 2 * W, -1);
      clear_log();
      wait_frame(8, "f8_start");
      cycles(2);
      chk("relock_quiet", qa0.size(), 0);
      chk("relock_locked", lk_lo, 1);
      wait_frame(9, "f9_start");
      cycles(2);
      check_seq("f8", NW, -1);
      chk("terr_sticky", te_lo, 1);

      // Asynchronous reset while a write is held.
      clear_log();
      trig_len = 1000; trig_addr = 2;
      wait_line(10, "f9_l10");
      chk("pre_rst_valid", wr_lo.o_wrValid, 1);
      chk("pre_rst_ovf", ov_lo, 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", wr_lo.o_wrValid, 0);
      chk("arst_addr", wr_lo.o_wrAddr, 0);
      chk("arst_data", wr_lo.o_wrData, 0);
      chk("arst_locked", lk_lo, 0);
      chk("arst_ovf", ov_lo, 0);
      chk("arst_terr", te_lo, 0);
      chk("arst_done", fd_lo, 0);
      chk("arst_valid_hi", wr_hi.o_wrValid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
